// File: rtl/a2d_rr_pkg.sv
// Shared types and constants for the round-robin A2D scheduler.
// Holds the FSM state type, slot index type, channel defaults and the SPI command builder.
package a2d_rr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXmit1,
        StGap,
        StXmit2
    } state_e;

    typedef logic [1:0] slot_t;

    localparam int unsigned NumSlots     = 4;
    localparam int unsigned ResW         = 12;
    localparam int unsigned CmdW         = 16;
    localparam int unsigned CmdChnlShift = 11;

    localparam logic [2:0]  DefChLft   = 3'd0;
    localparam logic [2:0]  DefChRght  = 3'd4;
    localparam logic [2:0]  DefChSteer = 3'd5;
    localparam logic [2:0]  DefChBatt  = 3'd6;
    localparam int unsigned DefTmoCyc  = 1024;

    // ADC128S control word: channel address in [13:11], everything else zero.
    function automatic logic [CmdW-1:0] mk_cmd(input logic [2:0] chnl);
        return CmdW'(chnl) << CmdChnlShift;
    endfunction

endpackage

// File: rtl/a2d_rr_sched_if.sv
// SPI-monarch side handshake of the A2D scheduler.
// The scheduler drives wrt/cmd (master); the SPI monarch returns done/rd_data (slave).
interface a2d_rr_sched_if;
    import a2d_rr_pkg::*;

    logic            wrt;
    logic [CmdW-1:0] cmd;
    logic            done;
    logic [CmdW-1:0] rd_data;

    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );

endinterface

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D scheduler: each request runs a two-transaction SPI conversion on the
// current slot, stores the 12-bit result and advances the slot; a watchdog aborts stalls.
module a2d_rr_sched
    import a2d_rr_pkg::*;
#(
    parameter logic [2:0]  CH_LFT   = DefChLft,
    parameter logic [2:0]  CH_RGHT  = DefChRght,
    parameter logic [2:0]  CH_STEER = DefChSteer,
    parameter logic [2:0]  CH_BATT  = DefChBatt,
    parameter int unsigned TMO_CYC  = DefTmoCyc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nxt,
    a2d_rr_sched_if.master    spi,
    output logic [ResW-1:0]   lft_ld,
    output logic [ResW-1:0]   rght_ld,
    output logic [ResW-1:0]   steer_pot,
    output logic [ResW-1:0]   batt,
    output logic              cnv_vld,
    output slot_t             rr_idx,
    output logic              busy,
    output logic              tmo_err
);

    localparam int unsigned     CntW   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CntW-1:0] WdLast = CntW'(TMO_CYC - 1);

    state_e                       state_q, state_d;
    logic                         pending_q, pending_d;
    logic                         wrt_q, wrt_d;
    logic [CmdW-1:0]              cmd_q, cmd_d;
    logic                         cnv_vld_q, cnv_vld_d;
    logic                         busy_q, busy_d;
    logic                         tmo_err_q, tmo_err_d;
    slot_t                        rr_idx_q, rr_idx_d;
    logic [CntW-1:0]              wd_cnt_q, wd_cnt_d;
    logic [NumSlots-1:0][ResW-1:0] res_q, res_d;

    logic [NumSlots-1:0][2:0]     chnl_tbl;
    logic                         wd_tc;
    logic                         unused_rd_hi;

    assign chnl_tbl     = {CH_BATT, CH_STEER, CH_RGHT, CH_LFT};
    assign wd_tc        = (wd_cnt_q == WdLast);
    assign unused_rd_hi = ^spi.rd_data[CmdW-1:ResW];

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wrt_d     = 1'b0;
        cmd_d     = cmd_q;
        cnv_vld_d = 1'b0;
        tmo_err_d = tmo_err_q;
        rr_idx_d  = rr_idx_q;
        wd_cnt_d  = wd_cnt_q;
        res_d     = res_q;

        // A request arriving mid-conversion is queued; a second one is simply lost.
        if (nxt && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (nxt || pending_q) begin
                    wrt_d     = 1'b1;
                    cmd_d     = mk_cmd(chnl_tbl[rr_idx_q]);
                    wd_cnt_d  = '0;
                    // Fresh request coinciding with a queued one: serve one, keep one queued.
                    pending_d = nxt && pending_q;
                    state_d   = StXmit1;
                end
            end

            StXmit1: begin
                if (spi.done) begin
                    state_d = StGap;
                end else if (wd_tc) begin
                    tmo_err_d = 1'b1;
                    rr_idx_d  = rr_idx_q + slot_t'(1);
                    state_d   = StIdle;
                end else begin
                    wd_cnt_d = wd_cnt_q + CntW'(1);
                end
            end

            StGap: begin
                wrt_d    = 1'b1;
                wd_cnt_d = '0;
                state_d  = StXmit2;
            end

            StXmit2: begin
                if (spi.done) begin
                    res_d[rr_idx_q] = spi.rd_data[ResW-1:0];
                    cnv_vld_d       = 1'b1;
                    rr_idx_d        = rr_idx_q + slot_t'(1);
                    state_d         = StIdle;
                end else if (wd_tc) begin
                    // Stalled read: skip this slot, keep the last good result.
                    tmo_err_d = 1'b1;
                    rr_idx_d  = rr_idx_q + slot_t'(1);
                    state_d   = StIdle;
                end else begin
                    wd_cnt_d = wd_cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Stays high across the idle hop between a finished and a queued conversion.
        busy_d = (state_d != StIdle) || pending_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            wrt_q     <= 1'b0;
            cmd_q     <= '0;
            cnv_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            rr_idx_q  <= '0;
            wd_cnt_q  <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            cnv_vld_q <= cnv_vld_d;
            busy_q    <= busy_d;
            tmo_err_q <= tmo_err_d;
            rr_idx_q  <= rr_idx_d;
            wd_cnt_q  <= wd_cnt_d;
            res_q     <= res_d;
        end
    end

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign cnv_vld   = cnv_vld_q;
    assign rr_idx    = rr_idx_q;
    assign busy      = busy_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: doc/a2d_rr_sched.md
Name: a2d_rr_sched

Overview:
- Round-robin scheduler that shares the single SPI link to the ADC128S among four analog sources: left load cell, right load cell, steer pot and battery.
- Each `nxt` strobe (from inertial `vld`) triggers one two-transaction A2D conversion on the current channel. The 12-bit result is latched into that channel's holding register, then the round-robin pointer advances.
- Sits between the balance/steer datapath consumers and the SPI monarch. Adds request queuing and a transaction watchdog.

Parameters:
- CH_LFT, 3'd0, ADC channel of left load cell
- CH_RGHT, 3'd4, ADC channel of right load cell
- CH_STEER, 3'd5, ADC channel of steer pot
- CH_BATT, 3'd6, ADC channel of battery
- TMO_CYC, 1024, max cycles waiting on `done` before abort

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- nxt  in  1  one-cycle request to start a conversion
- wrt  out  1  one-cycle pulse starting an SPI transaction
- cmd  out  16  SPI command word
- done  in  1  SPI transaction complete (one-cycle pulse)
- rd_data  in  16  SPI read data; [11:0] is the conversion result
- lft_ld  out  12  left load cell result
- rght_ld  out  12  right load cell result
- steer_pot  out  12  steer pot result
- batt  out  12  battery result
- cnv_vld  out  1  one-cycle pulse when any result register updates
- rr_idx  out  2  current round-robin slot (0 lft, 1 rght, 2 steer, 3 batt)
- busy  out  1  high in any non-IDLE state
- tmo_err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - all result registers 12'h000; `rr_idx` 0; `tmo_err` 0.
  - `wrt`, `cnv_vld`, `busy` are 0; `cmd` is 16'h0000; state is IDLE; pending flag is 0.
- `cmd` format is {2'b00, chnl[2:0], 11'h000}. `chnl` is selected by `rr_idx` from the CH_* parameters. `cmd` is registered and held stable from the `wrt` pulse until `done`.
- States:
  - IDLE: on `nxt` or pending flag, assert `wrt` for one cycle with the channel cmd. Clear pending. Go to XMIT1.
  - XMIT1: on `done`, go to GAP.
  - GAP: exactly one cycle. Then assert `wrt` for the second (read) transaction, with `cmd` unchanged. Go to XMIT2.
  - XMIT2: on `done`:
    - latch rd_data[11:0] into the register selected by `rr_idx`;
    - pulse `cnv_vld` the next cycle;
    - `rr_idx` <= `rr_idx`+1 (wraps 3->0);
    - go to IDLE.
- Latency: `nxt` to first `wrt` is 1 cycle. Second `done` to result-register update is 1 cycle, with `cnv_vld` in that same cycle.
- `nxt` while busy sets the pending flag. Only one request is queued; further `nxt` while pending is already set is dropped.
- Watchdog:
  - a counter clears on every `wrt` and increments in XMIT1/XMIT2;
  - reaching TMO_CYC-1 without `done` aborts to IDLE and sets `tmo_err` (sticky until `rst`);
  - on abort, the result register is not updated, `rr_idx` still advances, and no `cnv_vld` pulse is issued.
- `done` in the same cycle as the timeout terminal count: `done` wins; no error.
- `done` outside XMIT1/XMIT2 is ignored.
- `rst` mid-transaction: immediate return to IDLE with all reset values. Any pending request is discarded.
- Result registers change only on a successful XMIT2 completion and always hold the last good value.

Decomposition:
- Shared package a2d_rr_pkg holds:
  - state enum (IDLE, XMIT1, GAP, XMIT2);
  - slot index typedef (2 bits);
  - `cmd` field constants (channel shift 11);
  - default channel constants.
- No sub-module: one FSM, one watchdog counter and the result registers. The SPI monarch stays a separate existing block.

Test Plan:
- Reset, then one `nxt`; model returns 12'hA5C:
  - `cmd` = 16'h0000 on both `wrt` pulses;
  - `lft_ld` = 12'hA5C; `cnv_vld` pulses once; `rr_idx` = 1.
- Four `nxt` strobes spaced past completion, with data 12'h111/222/333/444:
  - `cmd` sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000;
  - registers lft/rght/steer/batt = 111/222/333/444; `rr_idx` wraps to 0.
- Three `nxt` strobes within one active transaction:
  - exactly two conversions complete (one queued, one dropped);
  - `busy` falls only after the second.
- `done` withheld: timeout fires at 1024 cycles after the first `wrt`:
  - `tmo_err` = 1; `lft_ld` unchanged at 12'h000; no `cnv_vld`; `rr_idx` = 1;
  - the next `nxt` proceeds normally on slot 1 (`cmd` 16'h2000).
- `rst` asserted during XMIT2:
  - all outputs return to reset values asynchronously;
  - a later `done` pulse is ignored; the next `nxt` targets slot 0.
- `done` coincident with the watchdog terminal count: result latched, `tmo_err` stays 0.
